// File: rtl/dmem_ctrl.sv
//==============================================================================
// Module      : dmem_ctrl
// Description : Data-memory controller for the ALU5 load/store port. One write
//               per held request, registered full-word read, access-fault flag.
//               Optional MMIO window (cycle counter, GPIO, scratch) is enabled
//               by defining DMEM_MMIO_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter logic [XLEN-1:0] MMIO_BASE   = 32'h2000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     mem_addr,
    input  logic [XLEN/8-1:0]   mem_byteen,
    input  logic                mem_we,
    input  logic                mem_req,
    input  logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN-1:0]     mem_rdata,
    output logic                mem_err,
    output logic [XLEN-1:0]     gpio_out
);

    localparam int              c_NB        = XLEN / 8;
    localparam int              c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] c_RAM_BYTES = XLEN'(4 * DEPTH_WORDS);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [XLEN-1:0] w_offset;
    logic [c_AW-1:0] w_idx;
    logic            w_accept;
    logic            w_misaligned;
    logic            w_be_ok;
    logic            w_in_ram;
    logic            w_in_mmio;
    logic            w_mmio_fault;
    logic            w_fault;
    logic            w_ram_we;
    logic [XLEN-1:0] w_mmio_rdata;
    logic [XLEN-1:0] w_rdata_next;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;
    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (mem_req) w_state_next = c_ST_ACCESS;
            c_ST_ACCESS: w_state_next = mem_req ? c_ST_HOLD : c_ST_IDLE;
            c_ST_HOLD:   if (!mem_req) w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    assign w_accept     = (r_state == c_ST_IDLE) && mem_req;
    assign w_misaligned = (mem_addr[1:0] != 2'b00);
    assign w_offset     = mem_addr - BASE_ADDR;
    assign w_idx        = w_offset[c_AW+1:2];
    assign w_in_ram     = (mem_addr >= BASE_ADDR) && (w_offset < c_RAM_BYTES);
    assign w_in_mmio    = (mem_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);

    always_comb begin
        w_be_ok = 1'b0;
        case (mem_byteen)
            c_NB'(4'b0001), c_NB'(4'b0010), c_NB'(4'b0100), c_NB'(4'b1000),
            c_NB'(4'b0011), c_NB'(4'b1100), c_NB'(4'b1111): w_be_ok = 1'b1;
            default: w_be_ok = 1'b0;
        endcase
    end

    assign w_fault  = w_misaligned | ~w_be_ok | ~(w_in_ram | w_in_mmio) | w_mmio_fault;
    assign w_ram_we = w_accept && !w_fault && w_in_ram && mem_we;

`ifdef DMEM_MMIO_EN
    logic [63:0]     r_cycle;
    logic [XLEN-1:0] r_gpio;
    logic [XLEN-1:0] r_scratch;
    logic            w_mmio_we;

    // Counter words are read-only; every MMIO access must be a full word.
    assign w_mmio_fault = w_in_mmio && ((mem_byteen != '1) || (mem_we && !mem_addr[3]));
    assign w_mmio_we    = w_accept && !w_fault && w_in_mmio && mem_we;

    always_comb begin
        w_mmio_rdata = '0;
        case (mem_addr[3:2])
            2'd0: w_mmio_rdata = XLEN'(r_cycle[31:0]);
            2'd1: w_mmio_rdata = XLEN'(r_cycle[63:32]);
            2'd2: w_mmio_rdata = r_gpio;
            default: w_mmio_rdata = r_scratch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle   <= 64'd0;
            r_gpio    <= '0;
            r_scratch <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_mmio_we && mem_addr[3:2] == 2'd2) r_gpio    <= mem_wdata;
            if (w_mmio_we && mem_addr[3:2] == 2'd3) r_scratch <= mem_wdata;
        end
    end

    assign gpio_out = r_gpio;
`else
    assign w_mmio_fault = w_in_mmio;
    assign w_mmio_rdata = '0;
    assign gpio_out     = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst && w_ram_we) begin
            for (int i = 0; i < c_NB; i++) begin
                if (mem_byteen[i]) r_mem[w_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_rdata_next = '0;
        if (!w_fault && !mem_we) begin
            w_rdata_next = w_in_ram ? r_mem[w_idx] : w_mmio_rdata;
        end
    end

    // Results are captured once at acceptance and cleared on the way back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_rdata_next;
            r_err   <= w_fault;
        end else if (w_state_next == c_ST_IDLE) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
//==============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking scoreboard bench for dmem_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_byteen = '0;
    logic        mem_we = 1'b0;
    logic        mem_req = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] gpio_out;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eerr;
    } op_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    dmem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_we     (mem_we),
        .mem_req    (mem_req),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .gpio_out   (gpio_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    // Drives a request, records its expected result, returns in cycle N+1.
    task automatic start_req(input op_t o);
        @(negedge clk);
        mem_addr   = o.a;
        mem_byteen = o.be;
        mem_we     = o.we;
        mem_wdata  = o.wd;
        mem_req    = 1'b1;
        sb.push_back('{rd: o.erd, err: o.eerr, chk_rd: (!o.we || o.eerr)});
        @(posedge clk);
        #1;
    endtask

    // Holds the request for extra cycles, drops it, leaves one clean IDLE cycle.
    task automatic end_req(input int hold);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (mem_rdata !== 32'h0 || mem_err !== 1'b0 || gpio_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: rdata=%h err=%b gpio=%h, expected 0/0/0", mem_rdata, mem_err, gpio_out);
        end
    endtask

    task automatic test_counter;
        exp_t e;
        op_t  ops[$];
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
`ifdef DMEM_MMIO_EN
        ops.push_back('{32'h2000_0000, 4'hF, 1'b0, 32'h0, 32'd10, 1'b0});
        ops.push_back('{32'h2000_0004, 4'hF, 1'b0, 32'h0, 32'd0,  1'b0});
`else
        ops.push_back('{32'h2000_0000, 4'hF, 1'b0, 32'h0, 32'd0, 1'b1});
        ops.push_back('{32'h2000_0004, 4'hF, 1'b0, 32'h0, 32'd0, 1'b1});
`endif
        foreach (ops[i]) begin
            start_req(ops[i]);
            e = sb.pop_front();
            vectors++;
            if (mem_err !== e.err || (e.chk_rd && mem_rdata !== e.rd)) begin
                miscompares++;
                $display("FAIL counter[%0d]: rdata=%h err=%b, expected rdata=%h err=%b", i, mem_rdata, mem_err, e.rd, e.err);
            end
            end_req(0);
        end
    endtask

    task automatic test_store_load;
        exp_t e;
        op_t  ops[$];
        ops.push_back('{32'h1000_0004, 4'hF, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0004, 4'hF, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0});
        ops.push_back('{32'h1000_0FFC, 4'hF, 1'b1, 32'hCAFE_F00D, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0FFC, 4'hF, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0});
        ops.push_back('{32'h1000_0000, 4'hF, 1'b1, 32'hA5A5_A5A5, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0000, 4'hF, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0});
        foreach (ops[i]) begin
            start_req(ops[i]);
            e = sb.pop_front();
            vectors++;
            if (mem_err !== e.err || (e.chk_rd && mem_rdata !== e.rd)) begin
                miscompares++;
                $display("FAIL store_load[%0d]: rdata=%h err=%b, expected rdata=%h err=%b", i, mem_rdata, mem_err, e.rd, e.err);
            end
            end_req(i % 2);
        end
    endtask

    task automatic test_byte_lanes;
        exp_t e;
        op_t  ops[$];
        ops.push_back('{32'h1000_0004, 4'b0100, 1'b1, 32'h00AB_0000, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0004, 4'b1111, 1'b0, 32'h0,         32'hDEAB_BEEF, 1'b0});
        ops.push_back('{32'h1000_0004, 4'b0001, 1'b0, 32'h0,         32'hDEAB_BEEF, 1'b0});
        ops.push_back('{32'h1000_0008, 4'b1111, 1'b1, 32'h1234_5678, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0008, 4'b1100, 1'b1, 32'hCAFE_0000, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0008, 4'b1111, 1'b0, 32'h0,         32'hCAFE_5678, 1'b0});
        ops.push_back('{32'h1000_0008, 4'b0001, 1'b1, 32'h0000_00EE, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0008, 4'b0010, 1'b1, 32'h0000_DD00, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0008, 4'b1000, 1'b1, 32'h7700_0000, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0008, 4'b1111, 1'b0, 32'h0,         32'h77FE_DDEE, 1'b0});
        ops.push_back('{32'h1000_0008, 4'b0011, 1'b1, 32'h0000_1234, 32'h0,         1'b0});
        ops.push_back('{32'h1000_0008, 4'b1111, 1'b0, 32'h0,         32'h77FE_1234, 1'b0});
        foreach (ops[i]) begin
            start_req(ops[i]);
            e = sb.pop_front();
            vectors++;
            if (mem_err !== e.err || (e.chk_rd && mem_rdata !== e.rd)) begin
                miscompares++;
                $display("FAIL byte_lanes[%0d]: rdata=%h err=%b, expected rdata=%h err=%b", i, mem_rdata, mem_err, e.rd, e.err);
            end
            end_req(0);
        end
    endtask

    task automatic test_held_request;
        exp_t e;
        start_req('{32'h1000_000C, 4'hF, 1'b1, 32'h0102_0304, 32'h0, 1'b0});
        e = sb.pop_front();
        vectors++;
        if (mem_err !== e.err) begin
            miscompares++;
            $display("FAIL held_store: err=%b, expected err=%b", mem_err, e.err);
        end
        @(negedge clk);
        mem_wdata = 32'h1111_1111;
        end_req(3);
        start_req('{32'h1000_000C, 4'hF, 1'b0, 32'h0, 32'h0102_0304, 1'b0});
        e = sb.pop_front();
        @(negedge clk);
        mem_addr = 32'h1000_0004;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (mem_err !== e.err || mem_rdata !== e.rd) begin
                miscompares++;
                $display("FAIL held_load[%0d]: rdata=%h err=%b, expected rdata=%h err=%b", k, mem_rdata, mem_err, e.rd, e.err);
            end
            @(posedge clk);
            #1;
        end
        end_req(0);
    endtask

    task automatic test_faults;
        exp_t e;
        op_t  ops[$];
        ops.push_back('{32'h1000_1000, 4'hF,    1'b0, 32'h0,         32'h0,         1'b1});
        ops.push_back('{32'h1000_0002, 4'hF,    1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1});
        ops.push_back('{32'h1000_0000, 4'hF,    1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0});
        ops.push_back('{32'h1000_0004, 4'b0101, 1'b0, 32'h0,         32'h0,         1'b1});
        ops.push_back('{32'h1000_0004, 4'b0101, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1});
        ops.push_back('{32'h1000_0004, 4'b0000, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1});
        ops.push_back('{32'h1000_0004, 4'hF,    1'b0, 32'h0,         32'hDEAB_BEEF, 1'b0});
        ops.push_back('{32'h0FFF_FFFC, 4'hF,    1'b0, 32'h0,         32'h0,         1'b1});
        ops.push_back('{32'h3000_0000, 4'hF,    1'b1, 32'h1,         32'h0,         1'b1});
        foreach (ops[i]) begin
            start_req(ops[i]);
            e = sb.pop_front();
            vectors++;
            if (mem_err !== e.err || (e.chk_rd && mem_rdata !== e.rd)) begin
                miscompares++;
                $display("FAIL faults[%0d]: rdata=%h err=%b, expected rdata=%h err=%b", i, mem_rdata, mem_err, e.rd, e.err);
            end
            end_req(1);
        end
    endtask

    task automatic test_reset_mid_access;
        exp_t e;
        op_t  ops[$];
        start_req('{32'h1000_0010, 4'hF, 1'b1, 32'h0000_0077, 32'h0, 1'b0});
        void'(sb.pop_front());
        end_req(0);
        start_req('{32'h1000_0010, 4'hF, 1'b0, 32'h0, 32'h0000_0077, 1'b0});
        e = sb.pop_front();
        vectors++;
        if (mem_rdata !== e.rd || mem_err !== e.err) begin
            miscompares++;
            $display("FAIL rst_mid_load: rdata=%h err=%b, expected rdata=%h err=%b", mem_rdata, mem_err, e.rd, e.err);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (mem_rdata !== 32'h0 || mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_hold: rdata=%h err=%b, expected 0/0", mem_rdata, mem_err);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_req = 1'b0;
        repeat (2) @(posedge clk);
        // Reset coinciding with acceptance must suppress the store.
        @(negedge clk);
        mem_addr = 32'h1000_0010; mem_byteen = 4'hF; mem_we = 1'b1;
        mem_wdata = 32'h0000_0099; mem_req = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (mem_rdata !== 32'h0 || mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_at_accept: rdata=%h err=%b, expected 0/0", mem_rdata, mem_err);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_req = 1'b0;
        repeat (2) @(posedge clk);
        ops.push_back('{32'h1000_0010, 4'hF, 1'b0, 32'h0, 32'h0000_0077, 1'b0});
        ops.push_back('{32'h1000_0004, 4'hF, 1'b0, 32'h0, 32'hDEAB_BEEF, 1'b0});
        foreach (ops[i]) begin
            start_req(ops[i]);
            e = sb.pop_front();
            vectors++;
            if (mem_err !== e.err || mem_rdata !== e.rd) begin
                miscompares++;
                $display("FAIL rst_readback[%0d]: rdata=%h err=%b, expected rdata=%h err=%b", i, mem_rdata, mem_err, e.rd, e.err);
            end
            end_req(0);
        end
    endtask

    task automatic test_mmio;
        exp_t e;
        op_t  ops[$];
        logic [31:0] exp_gpio;
`ifdef DMEM_MMIO_EN
        exp_gpio = 32'h0000_005A;
        ops.push_back('{32'h2000_0008, 4'hF,    1'b1, 32'h0000_005A, 32'h0,         1'b0});
        ops.push_back('{32'h2000_0008, 4'hF,    1'b0, 32'h0,         32'h0000_005A, 1'b0});
        ops.push_back('{32'h2000_000C, 4'hF,    1'b1, 32'h1234_5678, 32'h0,         1'b0});
        ops.push_back('{32'h2000_000C, 4'hF,    1'b0, 32'h0,         32'h1234_5678, 1'b0});
        ops.push_back('{32'h2000_0000, 4'hF,    1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1});
        ops.push_back('{32'h2000_0004, 4'hF,    1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1});
        ops.push_back('{32'h2000_0008, 4'b0011, 1'b1, 32'h0000_FFFF, 32'h0,         1'b1});
        ops.push_back('{32'h2000_0008, 4'b0001, 1'b0, 32'h0,         32'h0,         1'b1});
`else
        exp_gpio = 32'h0;
        ops.push_back('{32'h2000_0008, 4'hF, 1'b1, 32'h0000_005A, 32'h0, 1'b1});
        ops.push_back('{32'h2000_0008, 4'hF, 1'b0, 32'h0,         32'h0, 1'b1});
        ops.push_back('{32'h2000_000C, 4'hF, 1'b0, 32'h0,         32'h0, 1'b1});
`endif
        foreach (ops[i]) begin
            start_req(ops[i]);
            e = sb.pop_front();
            vectors++;
            if (mem_err !== e.err || (e.chk_rd && mem_rdata !== e.rd) || gpio_out !== exp_gpio) begin
                miscompares++;
                $display("FAIL mmio[%0d]: rdata=%h err=%b gpio=%h, expected rdata=%h err=%b gpio=%h",
                         i, mem_rdata, mem_err, gpio_out, e.rd, e.err, exp_gpio);
            end
            end_req(0);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        op_t  o;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 6; i++) begin
                o = '{32'h1000_0100 + 32'(4 * i), 4'hF, (pass == 0), 32'(i + 1) * 32'h0101_0101,
                      (pass == 0) ? 32'h0 : 32'(i + 1) * 32'h0101_0101, 1'b0};
                start_req(o);
                e = sb.pop_front();
                vectors++;
                if (mem_err !== e.err || (e.chk_rd && mem_rdata !== e.rd)) begin
                    miscompares++;
                    $display("FAIL b2b[%0d.%0d]: rdata=%h err=%b, expected rdata=%h err=%b", pass, i, mem_rdata, mem_err, e.rd, e.err);
                end
                end_req(i % 3);
                vectors++;
                if (mem_rdata !== 32'h0 || mem_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_idle[%0d.%0d]: rdata=%h err=%b, expected 0/0", pass, i, mem_rdata, mem_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_store_load();
        test_byte_lanes();
        test_held_request();
        test_faults();
        test_reset_mid_access();
        test_mmio();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
